// File: rtl/poets_onchip_mem_pipelined.sv
// Single-port on-chip RAM with an Avalon-MM slave interface.
// Reads go through a fixed-latency pipeline that can be stalled.
// Writes use per-byte enables and can be gated by debug protect and by freeze.
`timescale 1ns/1ps
module poets_onchip_mem_pipelined #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter bit WRITE_PROTECT = 1'b1,
    parameter     INIT_FILE     = "onchip_mem.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    debugaccess,
    input  logic                    freeze,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The vendor RAM inference picks up the preload image from this attribute.
    // Reset never touches the array.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  stall_s;
    logic                  rd_acc_s;
    logic                  wr_ok_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Stage i holds the read result after i+1 unstalled edges.
    // The last stage drives the outputs.
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

    assign stall_s   = ~clken | reset_req;
    assign rd_acc_s  = chipselect & read & ~write & ~stall_s;
    // Reset outranks any request, so a write is also dropped on a reset edge.
    assign wr_ok_s   = chipselect & write & ~freeze & ~stall_s & ~reset
                       & (debugaccess | ~WRITE_PROTECT);
    assign rd_word_s = mem_q[address];

    // Byte-lane RAM write. It has no reset because the contents must survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    mem_q[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Next state of the read pipeline.
    // A data stage loads only when valid data arrives, so readdata holds between beats.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (!stall_s) begin
            vld_d[0] = rd_acc_s;
            if (rd_acc_s) begin
                dat_d[0] = rd_word_s;
            end else begin
                dat_d[0] = dat_q[0];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                end else begin
                    dat_d[i] = dat_q[i];
                end
            end
        end else begin
            vld_d = vld_q;
            dat_d = dat_q;
        end
    end

    // Read pipeline registers. Reset clears them, which discards any in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_poets_onchip_mem_pipelined.sv
// Scoreboard bench that checks read latencies 1, 2 and 3 side by side.
// All three instances share one stimulus stream.
`timescale 1ns/1ps
module tb_poets_onchip_mem_pipelined;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        int unsigned   u;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, reset_req, clken, chipselect, read, write, debugaccess, freeze;
    logic [AW-1:0] address;
    logic [BW-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] rdata [3];
    logic          rvld  [3];

    int            checks   = 0;
    int            failures = 0;
    int unsigned   ucnt     = 0;   // count of unstalled, non-reset edges
    logic [DW-1:0] model [256];
    exp_t          exp_q [3][$];
    logic [DW-1:0] last_q [3];
    bit            clr_pend = 1'b1;
    exp_t          e_mon;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        poets_onchip_mem_pipelined #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(g + 1),
            .WRITE_PROTECT(1'b1), .INIT_FILE("onchip_mem.hex")
        ) u_dut (
            .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
            .address(address), .chipselect(chipselect), .read(read), .write(write),
            .byteenable(byteenable), .writedata(writedata), .debugaccess(debugaccess),
            .freeze(freeze), .readdata(rdata[g]), .readdatavalid(rvld[g])
        );
    end

    // One bus cycle: close the bookkeeping for the cycle that just ended,
    // then drive the new inputs and apply their effect to the reference model.
    task automatic step(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic dbg,
                        input logic frz, input logic ce, input logic rr, input logic rst);
        exp_t e;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 3; i++) exp_q[i].delete();
        end else if (clken && !reset_req) begin
            ucnt++;
        end
        #1;
        chipselect = cs; read = rd; write = wr; address = a; byteenable = be;
        writedata = wd; debugaccess = dbg; freeze = frz; clken = ce;
        reset_req = rr; reset = rst;
        if (!rst && ce && !rr && cs) begin
            if (wr) begin
                if (!frz && dbg) begin
                    for (int b = 0; b < BW; b++)
                        if (be[b]) model[a][8*b +: 8] = wd[8*b +: 8];
                end
            end else if (rd) begin
                e.data = model[a];
                e.u    = ucnt;
                for (int i = 0; i < 3; i++) exp_q[i].push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                         input logic dbg, input logic frz);
        step(1'b1, 1'b0, 1'b1, a, be, d, dbg, frz, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd_op(input logic [AW-1:0] a);
        step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: counts a beat only on an unstalled cycle and checks its data and latency.
    // Between beats it checks that readdata holds its last value.
    always @(negedge clk) begin
        if (reset) begin
            clr_pend = 1'b1;
        end else begin
            if (clr_pend) begin
                for (int i = 0; i < 3; i++) last_q[i] = '0;
                clr_pend = 1'b0;
            end
            if (clken && !reset_req) begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (rvld[i]) begin
                        if (exp_q[i].size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_beat lat=%0d got=%h required=no beat", i + 1, rdata[i]);
                        end else begin
                            e_mon = exp_q[i].pop_front();
                            if (rdata[i] !== e_mon.data || (ucnt - e_mon.u) != (i + 1)) begin
                                failures++;
                                $display("FAIL rd_beat lat=%0d got=%h after %0d cycles required=%h after %0d cycles",
                                         i + 1, rdata[i], ucnt - e_mon.u, e_mon.data, i + 1);
                            end
                        end
                        last_q[i] = rdata[i];
                    end else if (rdata[i] !== last_q[i]) begin
                        failures++;
                        $display("FAIL rd_hold lat=%0d got=%h required=%h", i + 1, rdata[i], last_q[i]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; reset_req = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0;
        write = 1'b0; debugaccess = 1'b0; freeze = 1'b0; address = '0; byteenable = '0;
        writedata = '0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        // Preload addresses 0..15 with addr*3.
        for (int a = 0; a < 16; a++) wr_op(a[7:0], 32'(a * 3), 4'hF, 1'b1, 1'b0);
        // Full write, then read back.
        wr_op(8'h05, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
        rd_op(8'h05);
        repeat (4) idle();
        // Partial write on lanes 0 and 2.
        wr_op(8'h05, 32'h11223344, 4'h5, 1'b1, 1'b0);
        rd_op(8'h05);
        // Writes blocked by protect and by freeze; no-lane write.
        wr_op(8'h05, 32'h0, 4'hF, 1'b0, 1'b0);
        rd_op(8'h05);
        wr_op(8'h05, 32'h0, 4'hF, 1'b1, 1'b1);
        rd_op(8'h05);
        wr_op(8'h05, 32'h0, 4'h0, 1'b1, 1'b0);
        rd_op(8'h05);
        repeat (4) idle();
        // Streaming burst with a 2-cycle clken drop and a reset_req stall.
        for (int a = 0; a < 4; a++) rd_op(a[7:0]);
        repeat (2) step(1'b1, 1'b1, 1'b0, 8'h04, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int a = 4; a < 6; a++) rd_op(a[7:0]);
        step(1'b1, 1'b1, 1'b0, 8'h06, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int a = 6; a < 8; a++) rd_op(a[7:0]);
        repeat (5) idle();
        // Reset mid-operation: the in-flight reads must never return.
        rd_op(8'h03);
        step(1'b1, 1'b1, 1'b0, 8'h04, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rvld[i] !== 1'b0 || rdata[i] !== '0) begin
                failures++;
                $display("FAIL post_reset lat=%0d got vld=%b data=%h required vld=0 data=0",
                         i + 1, rvld[i], rdata[i]);
            end
        end
        rd_op(8'h05);
        repeat (4) idle();
        // Read and write together: only the write happens.
        step(1'b1, 1'b1, 1'b1, 8'h09, 4'hF, 32'hA5A55A5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();
        rd_op(8'h09);
        repeat (4) idle();
        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 8'($urandom_range(0, 15)), 4'($urandom), $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0);
        end
        repeat (8) idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                failures++;
                $display("FAIL drain lat=%0d outstanding=%0d required=0", i + 1, exp_q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/poets_onchip_mem_pipelined.md
Name: poets_onchip_mem_pipelined

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM slave. It replaces the fixed 32x8, unregistered-output scratch memory in the POETS streaming system. It adds configurable width, depth and read latency, per-byte write enables, and a readdatavalid pipeline. Writes can be gated by a debug-access protect mode and by freeze. It sits on the system interconnect as a boot/config store, with contents preloaded from INIT_FILE.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8, 8..128
ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH words
READ_LATENCY, 2, cycles from accepted read to readdatavalid; legal 1..3
WRITE_PROTECT, 1, 1: writes require debugaccess=1; 0: debugaccess ignored
INIT_FILE, "onchip_mem.hex", memory initialisation file; array contents are not affected by reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
reset_req  in  1  pending-reset request; acts as a stall (see Behaviour)
clken  in  1  clock enable; 0 stalls the block
address  in  ADDR_WIDTH  word address
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
byteenable  in  DATA_WIDTH/8  per-byte write enable
writedata  in  DATA_WIDTH  write data
debugaccess  in  1  debug master access qualifier
freeze  in  1  1 blocks all writes
readdata  out  DATA_WIDTH  read data, valid only when readdatavalid=1
readdatavalid  out  1  one-cycle pulse per completed read

Behaviour:
- Reset (clk edge with reset=1): readdatavalid=0, readdata=0, all internal valid/data pipeline stages cleared. In-flight reads are discarded and never return. RAM contents are unchanged.
- The block is fixed-latency with no waitrequest. Every request is accepted unless stalled.
- stall = ~clken | reset_req. While stalled: no request is accepted, the RAM is not written, and the pipeline registers hold their values. readdatavalid holds its level; the bench counts a held valid as one beat only when stall=0.
- rd_acc = chipselect & read & ~write & ~stall.
- wr_ok = chipselect & write & ~freeze & ~stall & (debugaccess | ~WRITE_PROTECT).
- If read and write are both asserted, the request is a write only and no readdatavalid is produced.
- Write: on the accept edge, byte lane i (bits 8i+7:8i) is updated iff byteenable[i]=1. If byteenable=0, nothing changes. A write rejected by protect or freeze is silently dropped; no error response.
- Read: the RAM is sampled on the accept edge (stage 1). The data then moves through READ_LATENCY-1 further registers. readdatavalid=1 exactly READ_LATENCY unstalled cycles after acceptance. Back-to-back reads give full throughput, one result per cycle, in order.
- Read-during-write: a read accepted on the cycle immediately after a write to the same address returns the new data. There is no same-cycle conflict, because a single port accepts one operation per cycle.
- readdata holds its last value while readdatavalid=0. It is driven to 0 only by reset.
- Address wrap: none. Every address in 0..2**ADDR_WIDTH-1 is valid.
- Reset has priority over stall and over all requests.

Test Plan:
1. DATA_WIDTH=32, READ_LATENCY=2, WRITE_PROTECT=1: write 0xDEADBEEF to addr 0x05 with debugaccess=1, byteenable=0xF, then read 0x05 -> readdatavalid pulses exactly 2 cycles after read accept with readdata=0xDEADBEEF.
2. Partial write: write 0x11223344 with byteenable=0x5 to addr 0x05 (which holds 0xDEADBEEF) -> subsequent read returns 0xDE22BE44.
3. Protection: with debugaccess=0, write 0x0 to addr 0x05 -> read still returns 0xDE22BE44. Repeat with debugaccess=1 and freeze=1 -> value still unchanged.
4. Streaming: back-to-back reads of addrs 0..7 (preloaded data = addr*3) -> eight consecutive readdatavalid pulses returning 0,3,...,21 in order. Drop clken for 2 cycles mid-burst -> sequence extends by 2 cycles, no beat lost or duplicated.
5. Reset mid-operation: issue 2 reads, assert reset on the next cycle -> no readdatavalid ever appears for them, and readdata=0 after reset. A read issued after reset returns the pre-reset RAM contents.
6. READ_LATENCY=1 and 3 builds: repeat scenario 1 -> valid after 1 and 3 cycles respectively. Simultaneous read+write to addr 0x09 -> write occurs, no readdatavalid.
